cpu_lsu_wb: RTL and testbench
=============================

# cpu_lsu_wb

Parametrised load/store unit between the CPU execute stage and the word-addressed pipelined Wishbone data bus. Takes one byte, halfword or word request at a time, drives the byte lanes, sign- or zero-extends load data, and returns a single-cycle ack or error. It adds a bus timeout and error reporting, and can optionally split misaligned accesses that cross a word boundary into two bus beats.

## Interface
- ADDR_W, 32: CPU byte-address width. The bus word address is ADDR_W-2 bits.
- TIMEOUT, 255: cycles to wait for ack per beat. 0 disables the timeout.
- i_clk  in  1  clock. Reset is i_reset, synchronous, active-high; the clock is i_clk.
- i_reset  in  1  synchronous active-high reset.
- i_stb  in  1  CPU request strobe.
- i_we  in  1  1 = store, 0 = load.
- i_addr  in  ADDR_W  byte address.
- i_data  in  32  store data, right-aligned.
- i_sel  in  3  access size: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. All other codes are illegal.
- o_stall  out  1  high whenever the unit is not IDLE.
- o_ack  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error pulse, mutually exclusive with o_ack.
- o_data  out  32  load result, valid while o_ack is high.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone cycle, strobe and write enable.
- o_wb_addr  out  ADDR_W-2  word address.
- o_wb_data  out  32  lane-aligned store data. Unused lanes drive 0.
- o_wb_sel  out  4  byte-lane enables.
- i_wb_stall, i_wb_ack, i_wb_err  in  1  Wishbone slave responses.
- i_wb_data  in  32  read data.

## Operation
- The request is captured in IDLE when i_stb is high. Address, data, size and we are latched.
- An illegal i_sel goes straight to RESP with error. No bus cycle is issued.
- States and transitions:
  - IDLE -> REQ1 on a legal request.
  - REQ1 -> WAIT1 when !i_wb_stall.
  - WAIT1 -> REQ2 on i_wb_ack when a split is needed, otherwise -> RESP.
  - REQ2 -> WAIT2 when !i_wb_stall.
  - WAIT2 -> RESP on i_wb_ack.
  - RESP -> IDLE.
- In REQ states: o_wb_cyc=1 and o_wb_stb=1. In WAIT states: o_wb_cyc=1 and o_wb_stb=0. o_wb_cyc stays high across both beats of a split.
- Lanes with offset k = addr[1:0]:
  - Byte: sel = 0001<<k, data = d[7:0]<<8k.
  - Half: sel = 0011<<k, data = d[15:0]<<8k.
  - Word: sel = 1111<<k, data = d<<8k. All shifts are truncated to 4 and 32 bits.
- Second beat (crossing accesses only: half with k=3, word with k≠0):
  - Address = word+1, wrapping modulo 2^(ADDR_W-2).
  - Lanes: half uses sel 0001; word uses sel = 1111>>(4-k).
  - Data = d>>(32-8k) (word) or d>>8 (half).
- Load assembly: bytes are collected from the beat(s) and shifted right by 8k. Signed codes extend bit 7 or bit 15; unsigned codes zero-fill.
- Error: i_wb_err in either WAIT state, or the timeout counter reaching TIMEOUT:
  - drops cyc and stb on the next edge;
  - moves to RESP with o_err=1;
  - skips any second beat. A store whose first beat completed is not rolled back.
- The timeout counter clears on entry to each WAIT state and counts each WAIT cycle without ack.
- i_wb_ack and i_wb_err are ignored outside the WAIT states. If both arrive in the same cycle, err wins.

## Timing
- Reset values:
  - state IDLE;
  - o_ack, o_err, o_wb_cyc, o_wb_stb and o_wb_we = 0;
  - o_data = 0, o_wb_sel = 0, o_wb_data = 0, o_wb_addr = 0.
- o_stall is combinational from state. All other outputs are registered.
- Request accepted at cycle 0 → REQ1 at cycle 1. With no stall and ack in cycle 2, o_ack is high in cycle 3. Minimum latency is 3 cycles for one beat and 5 for a split.
- Each i_wb_stall cycle adds one cycle. Each ack wait cycle adds one cycle.
- i_stb while o_stall is high is ignored. A new request is accepted no earlier than the cycle after RESP.
- Reset mid-transaction returns to IDLE and deasserts cyc/stb at that edge. No ack or err is produced.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: crossing accesses are split into two beats as described above.
- LSU_MISALIGNED_SPLIT_EN undefined: any crossing access goes IDLE → RESP with o_err=1 and no bus cycle. Aligned and non-crossing accesses are unaffected.
- REQ2/WAIT2 and the assembly registers are omitted when the macro is undefined.

## Test plan
- Load byte signed at 0x1002, mem word 0x12F45678 → one beat, word addr 0x400, sel 0100; o_data=0xFFFFFFF4 at cycle 3.
- Store half 0xBEEF at 0x1001 → sel 0110, o_wb_data=0x00BEEF00, we=1; o_ack with no stall.
- Load word at 0x1003 with the macro defined, mem[0x400]=0xAA000000, mem[0x401]=0x00CCBBDD:
  - beats go to word addresses 0x400 and 0x401 with sel 1000 then 0111;
  - o_data=0xCCBBDDAA, o_ack at cycle 5.
- With the macro undefined, the same access → o_err at cycle 1 and o_wb_cyc never high.
- TIMEOUT=4, no ack → cyc drops after 4 WAIT cycles, o_err pulses once. i_wb_err on the first beat of a split → single o_err and no second beat.
- i_sel=011 → o_err and no bus cycle. Reset asserted in WAIT1 → cyc=0 next cycle, no o_ack, and a late i_wb_ack is ignored.

Source files
------------

// File: rtl/cpu_lsu_wb.sv
// Load/store unit bridging the execute stage to a pipelined Wishbone data bus.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two beats.
//
// state  | meaning
// IDLE   | ready, captures a request on i_stb
// REQ1   | first beat strobed, waiting for !i_wb_stall
// WAIT1  | first beat issued, waiting for ack/err/timeout
// REQ2   | second beat strobed (split builds only)
// WAIT2  | second beat issued (split builds only)
// RESP   | one-cycle o_ack or o_err
module cpu_lsu_wb #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    input  logic [2:0]        i_sel,
    output logic              o_stall,
    output logic              o_ack,
    output logic              o_err,
    output logic [31:0]       o_data,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-3:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    output logic [3:0]        o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [31:0]       i_wb_data
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_REQ2,
        S_WAIT2,
`endif
        S_RESP
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [2:0]        size_q;
    logic              we_q;
    logic [TMR_W-1:0]  tmr;
    logic              req_legal, req_cross, timeout;
    logic              ack_d, err_d, cyc_d, stb_d, load_b1;
    logic [31:0]       raw, ld_data;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              cross_q;
    logic [31:0]       rd_lo;
    logic              load_b2;
`endif

    function automatic logic [3:0] sel_beat1(input logic [1:0] sz, input logic [1:0] k);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << k;
    endfunction

    function automatic logic [31:0] data_beat1(input logic [1:0] sz, input logic [1:0] k,
                                               input logic [31:0] d);
        logic [31:0] m;
        case (sz)
            2'b00:   m = {24'b0, d[7:0]};
            2'b01:   m = {16'b0, d[15:0]};
            default: m = d;
        endcase
        return m << {k, 3'b000};
    endfunction

`ifdef LSU_MISALIGNED_SPLIT_EN
    function automatic logic [3:0] sel_beat2(input logic [1:0] sz, input logic [1:0] k);
        if (sz == 2'b01) return 4'b0001;
        return 4'b1111 >> (3'd4 - {1'b0, k});
    endfunction

    // Half second beat carries only byte 1; upper lanes stay zero.
    function automatic logic [31:0] data_beat2(input logic [1:0] sz, input logic [1:0] k,
                                               input logic [31:0] d);
        if (sz == 2'b01) return {24'b0, d[15:8]};
        return d >> (6'd32 - {1'b0, k, 3'b000});
    endfunction
`endif

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] r);
        case (code)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'b0, r[7:0]};
            3'b101:  return {16'b0, r[15:0]};
            default: return r;
        endcase
    endfunction

    always_comb begin
        case (i_sel)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
            default:                                req_legal = 1'b0;
        endcase
    end

    assign req_cross = ((i_sel[1:0] == 2'b01) && (i_addr[1:0] == 2'b11)) ||
                       ((i_sel[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign timeout   = (TIMEOUT != 0) && !i_wb_ack && (tmr == '0);
    assign o_stall   = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_stb) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (!req_legal) begin
`else
                    if (!req_legal || req_cross) begin
`endif
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ1;
                    end
                end
            end
            S_REQ1: if (!i_wb_stall) state_d = S_WAIT1;
            S_WAIT1: begin
                if (i_wb_err || timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (i_wb_ack) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (cross_q) begin
                        state_d = S_REQ2;
                    end else begin
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                    end
`else
                    state_d = S_RESP;
                    ack_d   = 1'b1;
`endif
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_REQ2: if (!i_wb_stall) state_d = S_WAIT2;
            S_WAIT2: begin
                if (i_wb_err || timeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (i_wb_ack) begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d   = (state_d != S_IDLE) && (state_d != S_RESP);
        stb_d   = (state_d == S_REQ1);
        load_b1 = (state == S_IDLE) && (state_d == S_REQ1);
        raw     = i_wb_data >> {addr_q[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        stb_d   = stb_d || (state_d == S_REQ2);
        load_b2 = (state == S_WAIT1) && (state_d == S_REQ2);
        // Split loads stitch the upper bytes of beat 1 with the low bytes of beat 2.
        if (state == S_WAIT2)
            raw = (rd_lo >> {addr_q[1:0], 3'b000}) |
                  (i_wb_data << (6'd32 - {1'b0, addr_q[1:0], 3'b000}));
`endif
        ld_data = extend(size_q, raw);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_data    <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_wb_sel  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            tmr       <= TMR_LOAD;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cross_q   <= 1'b0;
            rd_lo     <= '0;
`endif
        end else begin
            o_ack    <= ack_d;
            o_err    <= err_d;
            o_wb_cyc <= cyc_d;
            o_wb_stb <= stb_d;
            if (state == S_IDLE && i_stb) begin
                addr_q  <= i_addr;
                data_q  <= i_data;
                size_q  <= i_sel;
                we_q    <= i_we;
`ifdef LSU_MISALIGNED_SPLIT_EN
                cross_q <= req_cross;
`endif
            end
            if (load_b1) begin
                o_wb_addr <= i_addr[ADDR_W-1:2];
                o_wb_sel  <= sel_beat1(i_sel[1:0], i_addr[1:0]);
                o_wb_data <= data_beat1(i_sel[1:0], i_addr[1:0], i_data);
                o_wb_we   <= i_we;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (load_b2) begin
                o_wb_addr <= o_wb_addr + WA_W'(1);
                o_wb_sel  <= sel_beat2(size_q[1:0], addr_q[1:0]);
                o_wb_data <= data_beat2(size_q[1:0], addr_q[1:0], data_q);
            end
            if (state == S_WAIT1 && i_wb_ack) rd_lo <= i_wb_data;
            if (state == S_REQ1 || state == S_REQ2) tmr <= TMR_LOAD;
`else
            if (state == S_REQ1) tmr <= TMR_LOAD;
`endif
            else if (tmr != '0) tmr <= tmr - TMR_W'(1);
            if (ack_d && !we_q) o_data <= ld_data;
        end
    end

endmodule

// File: tb/tb_cpu_lsu_wb.sv
// Directed bench for cpu_lsu_wb (TIMEOUT=4); vector table plus hand sequences
// for reset mid-cycle, busy-strobe, err/ack collision and stray slave responses.
module tb_cpu_lsu_wb;

    logic        i_clk = 1'b0, i_reset = 1'b1, i_stb = 1'b0, i_we = 1'b0;
    logic [31:0] i_addr = '0, i_data = '0;
    logic [2:0]  i_sel = '0;
    logic        o_stall, o_ack, o_err;
    logic [31:0] o_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
    logic [31:0] i_wb_data = '0;

    int checks = 0;
    int failures = 0;

    cpu_lsu_wb #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_we(i_we),
        .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel),
        .o_stall(o_stall), .o_ack(o_ack), .o_err(o_err), .o_data(o_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
        logic [31:0] mem0, mem1;
        int          stalls, waits, err_beat;
        logic        exp_err;
        int          exp_lat, exp_beats;
        logic [29:0] exp_a0;
        logic [3:0]  exp_s0;
        logic [31:0] exp_d0;
        logic [29:0] exp_a1;
        logic [3:0]  exp_s1;
        logic [31:0] exp_d1;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [29:0] ba[2];
        logic [3:0]  bs[2];
        logic [31:0] bd[2];
        logic        bw[2];
        int nb = 0, lat = 0, stall_left, wait_left = 0;
        logic done = 1'b0, got_ack = 1'b0, got_err = 1'b0, cyc_done = 1'b0, stall_done = 1'b0;
        logic [31:0] rd = '0;
        stall_left = v.stalls;
        for (int b = 0; b < 2; b++) begin
            ba[b] = '0; bs[b] = '0; bd[b] = '0; bw[b] = 1'b0;
        end
        i_stb = 1'b1; i_we = v.we; i_addr = v.addr; i_data = v.data; i_sel = v.sel;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            i_stb = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
            if (o_ack || o_err) begin
                done = 1'b1; lat = c; got_ack = o_ack; got_err = o_err;
                rd = o_data; cyc_done = o_wb_cyc; stall_done = o_stall;
            end else if (o_wb_stb) begin
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    if (nb < 2) begin
                        ba[nb] = o_wb_addr; bs[nb] = o_wb_sel; bd[nb] = o_wb_data; bw[nb] = o_wb_we;
                    end
                    nb++;
                    wait_left = v.waits;
                end
            end else if (o_wb_cyc) begin
                if (v.err_beat == nb) i_wb_err = 1'b1;
                else if (wait_left > 0) wait_left--;
                else begin
                    i_wb_ack = 1'b1;
                    i_wb_data = (nb == 1) ? v.mem0 : v.mem1;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL v%0d_resp: got no ack/err within 40 cycles, expected one", idx);
        end else begin
            check($sformatf("v%0d_lat", idx), lat, v.exp_lat);
            check($sformatf("v%0d_ack", idx), got_ack, !v.exp_err);
            check($sformatf("v%0d_err", idx), got_err, v.exp_err);
            check($sformatf("v%0d_nbeats", idx), nb, v.exp_beats);
            check($sformatf("v%0d_cyc_at_resp", idx), cyc_done, 0);
            check($sformatf("v%0d_stall_at_resp", idx), stall_done, 1);
            if (v.exp_beats >= 1) begin
                check($sformatf("v%0d_addr0", idx), ba[0], v.exp_a0);
                check($sformatf("v%0d_sel0", idx), bs[0], v.exp_s0);
                check($sformatf("v%0d_wdata0", idx), bd[0], v.exp_d0);
                check($sformatf("v%0d_we0", idx), bw[0], v.we);
            end
            if (v.exp_beats >= 2) begin
                check($sformatf("v%0d_addr1", idx), ba[1], v.exp_a1);
                check($sformatf("v%0d_sel1", idx), bs[1], v.exp_s1);
                check($sformatf("v%0d_wdata1", idx), bd[1], v.exp_d1);
            end
            if (!v.we && !v.exp_err) check($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
            tick();
            check($sformatf("v%0d_single_pulse", idx), {o_ack, o_err, o_stall}, 0);
        end
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
    endtask

    initial begin
        int pulses, cycs, beats;
        // Fields: we addr data sel mem0 mem1 stalls waits err_beat | err lat beats a0 s0 d0 a1 s1 d1 rd
        vt.push_back('{0, 32'h1002, 0, 3'b000, 32'h12F45678, 0, 0, 0, 0, 0, 3, 1, 30'h400, 4'b0100, 0, 0, 0, 0, 32'hFFFFFFF4});
        vt.push_back('{1, 32'h1001, 32'h1234BEEF, 3'b001, 0, 0, 0, 0, 0, 0, 3, 1, 30'h400, 4'b0110, 32'h00BEEF00, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1003, 0, 3'b100, 32'h80123456, 0, 0, 0, 0, 0, 3, 1, 30'h400, 4'b1000, 0, 0, 0, 0, 32'h00000080});
        vt.push_back('{0, 32'h2002, 0, 3'b001, 32'h80011234, 0, 0, 0, 0, 0, 3, 1, 30'h800, 4'b1100, 0, 0, 0, 0, 32'hFFFF8001});
        vt.push_back('{0, 32'h2000, 0, 3'b101, 32'h12349ABC, 0, 0, 0, 0, 0, 3, 1, 30'h800, 4'b0011, 0, 0, 0, 0, 32'h00009ABC});
        vt.push_back('{0, 32'h3000, 0, 3'b010, 32'hDEADBEEF, 0, 2, 3, 0, 0, 8, 1, 30'hC00, 4'b1111, 0, 0, 0, 0, 32'hDEADBEEF});
        vt.push_back('{1, 32'h0004, 32'hCAFEF00D, 3'b010, 0, 0, 0, 0, 0, 0, 3, 1, 30'h001, 4'b1111, 32'hCAFEF00D, 0, 0, 0, 0});
        vt.push_back('{1, 32'h0007, 32'h123456A5, 3'b000, 0, 0, 0, 0, 0, 0, 3, 1, 30'h001, 4'b1000, 32'hA5000000, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1000, 0, 3'b011, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 32'h0000, 32'h11111111, 3'b110, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1000, 0, 3'b010, 0, 0, 0, 0, 1, 1, 3, 1, 30'h400, 4'b1111, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1000, 0, 3'b010, 0, 0, 0, 99, 0, 1, 6, 1, 30'h400, 4'b1111, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1001, 0, 3'b000, 32'h00007F00, 0, 0, 1, 0, 0, 4, 1, 30'h400, 4'b0010, 0, 0, 0, 0, 32'h0000007F});
`ifdef LSU_MISALIGNED_SPLIT_EN
        vt.push_back('{0, 32'h1003, 0, 3'b010, 32'hAA000000, 32'h00CCBBDD, 0, 0, 0, 0, 5, 2, 30'h400, 4'b1000, 0, 30'h401, 4'b0111, 0, 32'hCCBBDDAA});
        vt.push_back('{1, 32'h1003, 32'h1234BEEF, 3'b001, 0, 0, 0, 0, 0, 0, 5, 2, 30'h400, 4'b1000, 32'hEF000000, 30'h401, 4'b0001, 32'h000000BE, 0});
        vt.push_back('{0, 32'hFFFFFFFE, 0, 3'b010, 32'h55661111, 32'h22227788, 0, 0, 0, 0, 5, 2, 30'h3FFFFFFF, 4'b1100, 0, 30'h0, 4'b0011, 0, 32'h77885566});
        vt.push_back('{0, 32'h1001, 0, 3'b010, 0, 0, 0, 0, 1, 1, 3, 1, 30'h400, 4'b1110, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1003, 0, 3'b001, 32'h34000000, 32'h000000F2, 0, 0, 0, 0, 5, 2, 30'h400, 4'b1000, 0, 30'h401, 4'b0001, 0, 32'hFFFFF234});
        vt.push_back('{0, 32'h1002, 0, 3'b010, 0, 0, 0, 0, 2, 1, 5, 2, 30'h400, 4'b1100, 0, 30'h401, 4'b0011, 0, 0});
        vt.push_back('{1, 32'h1001, 32'h11223344, 3'b010, 0, 0, 0, 0, 0, 0, 5, 2, 30'h400, 4'b1110, 32'h22334400, 30'h401, 4'b0001, 32'h00000011, 0});
`else
        vt.push_back('{0, 32'h1003, 0, 3'b010, 32'hAA000000, 32'h00CCBBDD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 32'h1003, 32'h1234BEEF, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'hFFFFFFFE, 0, 3'b010, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h1001, 0, 3'b010, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 32'h1001, 32'h11223344, 3'b010, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
`endif

        i_reset = 1'b1;
        tick();
        tick();
        check("rst_ctrl", {o_stall, o_ack, o_err, o_wb_cyc, o_wb_stb, o_wb_we}, 0);
        check("rst_data", o_data, 0);
        check("rst_wb_addr", o_wb_addr, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_wb_sel", o_wb_sel, 0);
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

        // Reset while the first beat waits for ack; a late ack must be ignored.
        i_stb = 1'b1; i_we = 1'b0; i_addr = 32'h1000; i_sel = 3'b010; i_data = '0;
        tick();
        i_stb = 1'b0;
        check("rw_req_stb", {o_wb_cyc, o_wb_stb}, 2'b11);
        tick();
        check("rw_wait", {o_wb_cyc, o_wb_stb}, 2'b10);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rw_cyc_drop", {o_wb_cyc, o_wb_stb, o_stall, o_ack, o_err}, 0);
        i_wb_ack = 1'b1; i_wb_data = 32'hFFFFFFFF;
        pulses = 0; cycs = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 1) i_wb_ack = 1'b0;
            pulses += int'(o_ack) + int'(o_err);
            cycs += int'(o_wb_cyc);
        end
        check("rw_no_resp", pulses, 0);
        check("rw_no_cyc", cycs, 0);

        // i_stb held while busy is ignored; err and ack together report err.
        i_stb = 1'b1; i_addr = 32'h1000; i_sel = 3'b010;
        beats = 0;
        tick();
        i_addr = 32'h2000;
        beats += int'(o_wb_stb);
        tick();
        beats += int'(o_wb_stb);
        i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_data = 32'h12345678;
        tick();
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_stb = 1'b0;
        check("ae_resp", {o_err, o_ack, o_stall}, 3'b101);
        cycs = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            cycs += int'(o_wb_cyc);
        end
        check("busy_stb_beats", beats, 1);
        check("busy_stb_no_new_cyc", cycs, 0);
        check("busy_idle", o_stall, 0);

        // Stray ack/err while idle must not produce a response.
        i_wb_ack = 1'b1; i_wb_err = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            pulses += int'(o_ack) + int'(o_err) + int'(o_stall);
        end
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        check("idle_stray_resp", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
